// File: rtl/shift32_unit.sv
// -----------------------------------------------------------------------------
// shift32_unit
// Registered 32-bit logical barrel shifter for the ALU SLL/SRL operations.
// A five-stage right log-shifter (1, 2, 4, 8, 16) does all the shifting.
// Left shifts reuse the same stages: the operand is bit-reversed on the way in,
// shifted right, then reversed again on the way out. Any set bit in S[31:5]
// means the amount is 32 or more, so the result is forced to zero rather than
// being taken modulo 32.
//
// Ports
//   CLK  in   1   system clock, rising edge
//   RST  in   1   asynchronous active-low reset, clears Y
//   D    in   32  operand
//   S    in   32  unsigned shift amount
//   LnR  in   1   1 = shift left, 0 = shift right
//   Y    out  32  registered result, one cycle after D/S/LnR are sampled
// -----------------------------------------------------------------------------
module shift32_unit (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] D,
   input  logic [31:0] S,
   input  logic        LnR,
   output logic [31:0] Y
);

   // Mirror a word end-for-end so that a right shift acts as a left shift
   function automatic logic [31:0] bitReverse(input logic [31:0] data);
      logic [31:0] rev;
      for (int i = 0; i < 32; i++) begin
         rev[i] = data[31 - i];
      end
      return rev;
   endfunction

   // One log-shifter stage: shift right by amt when en is set, else pass through
   function automatic logic [31:0] shrStage(input logic [31:0] data,
                                            input logic        en,
                                            input int unsigned amt);
      logic [31:0] res;
      if (en) begin
         res = data >> amt;
      end else begin
         res = data;
      end
      return res;
   endfunction

   logic [31:0] shiftIn_s;
   logic [31:0] stage1_s;
   logic [31:0] stage2_s;
   logic [31:0] stage4_s;
   logic [31:0] stage8_s;
   logic [31:0] stage16_s;
   logic [31:0] shifted_s;
   logic        outOfRange_s;
   logic [31:0] result_s;
   logic [31:0] y_r;

   // Direction steering and the five right-shift stages
   always_comb begin
      shiftIn_s = 32'h0000_0000;
      shifted_s = 32'h0000_0000;

      if (LnR) begin
         shiftIn_s = bitReverse(D);
      end else begin
         shiftIn_s = D;
      end

      stage1_s  = shrStage(shiftIn_s, S[0], 32'd1);
      stage2_s  = shrStage(stage1_s,  S[1], 32'd2);
      stage4_s  = shrStage(stage2_s,  S[2], 32'd4);
      stage8_s  = shrStage(stage4_s,  S[3], 32'd8);
      stage16_s = shrStage(stage8_s,  S[4], 32'd16);

      if (LnR) begin
         shifted_s = bitReverse(stage16_s);
      end else begin
         shifted_s = stage16_s;
      end
   end

   // Amounts of 32 or more shift every bit out, in either direction
   always_comb begin
      outOfRange_s = |S[31:5];
      if (outOfRange_s) begin
         result_s = 32'h0000_0000;
      end else begin
         result_s = shifted_s;
      end
   end

   // Output register, cleared immediately by reset
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         y_r <= 32'h0000_0000;
      end else begin
         y_r <= result_s;
      end
   end

   assign Y = y_r;

endmodule

// File: tb/tb_shift32_unit.sv
// -----------------------------------------------------------------------------
// tb_shift32_unit
// Self-checking bench for shift32_unit: directed vectors with fixed expected
// values, followed by back-to-back random operations checked against a
// behavioural model written directly from the shift rules.
// -----------------------------------------------------------------------------
module tb_shift32_unit;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic [31:0] D   = 32'h0000_0000;
   logic [31:0] S   = 32'h0000_0000;
   logic        LnR = 1'b0;
   logic [31:0] Y;

   int passed = 0;
   int failed = 0;
   int total  = 0;

   always #5 CLK = ~CLK;

   shift32_unit dut (
      .CLK (CLK),
      .RST (RST),
      .D   (D),
      .S   (S),
      .LnR (LnR),
      .Y   (Y)
   );

   // Reference: logical shift, zero when the amount is 32 or more
   function automatic logic [31:0] refShift(input logic [31:0] d,
                                            input logic [31:0] s,
                                            input logic        lnr);
      longint unsigned wide;
      if (s >= 32'd32) return 32'h0000_0000;
      wide = {32'h0, d};
      if (lnr) wide = wide << s;
      else     wide = wide >> s;
      return wide[31:0];
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive one vector, let one rising edge capture it, then check Y
   task automatic step(input string tag, input logic lnr, input logic [31:0] s,
                       input logic [31:0] d, input logic [31:0] exp);
      LnR = lnr;
      S   = s;
      D   = d;
      @(posedge CLK);
      #1;
      check(tag, Y, exp);
   endtask

   initial begin
      logic [31:0] rd;
      logic [31:0] rs;
      logic        rl;
      logic [31:0] expY;
      int          sel;

      // Reset held while clocking an input that would give a nonzero result
      RST = 1'b0;
      D   = 32'hFFFF_FFFF;
      S   = 32'd1;
      LnR = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      check("reset_hold", Y, 32'h0000_0000);
      RST = 1'b1;

      // Basic left/right
      step("l1_64",  1'b1, 32'd1, 32'd64,  32'd128);
      step("r1_64",  1'b0, 32'd1, 32'd64,  32'd32);
      step("l8_100", 1'b1, 32'd8, 32'd100, 32'd25600);
      step("r8_100", 1'b0, 32'd8, 32'd100, 32'd0);
      step("l2_40",  1'b1, 32'd2, 32'd40,  32'd160);
      step("r2_40",  1'b0, 32'd2, 32'd40,  32'd10);

      // Asynchronous reset between edges while Y is nonzero
      step("pre_async", 1'b1, 32'd1, 32'h0000_0040, 32'h0000_0080);
      #2 RST = 1'b0;
      #1;
      check("async_reset", Y, 32'h0000_0000);
      #1 RST = 1'b1;

      // Stage coverage
      step("l20_1",  1'b1, 32'd20, 32'h0000_0001, 32'h0010_0000);
      step("r20_1",  1'b0, 32'd20, 32'h0000_0001, 32'h0000_0000);
      step("l31_1",  1'b1, 32'd31, 32'h0000_0001, 32'h8000_0000);
      step("r31_msb",1'b0, 32'd31, 32'h8000_0000, 32'h0000_0001);

      // Zero and out-of-range amounts
      step("l0_7",   1'b1, 32'd0,   32'd7, 32'd7);
      step("r0_7",   1'b0, 32'd0,   32'd7, 32'd7);
      step("l32_7",  1'b1, 32'd32,  32'd7, 32'd0);
      step("r32_7",  1'b0, 32'd32,  32'd7, 32'd0);
      step("l100_7", 1'b1, 32'd100, 32'd7, 32'd0);
      step("r100_7", 1'b0, 32'd100, 32'd7, 32'd0);
      step("l_big",  1'b1, 32'h8000_0001, 32'hFFFF_FFFF, 32'h0000_0000);
      step("r_big",  1'b0, 32'h8000_0001, 32'hFFFF_FFFF, 32'h0000_0000);

      // Zero fill in both directions
      step("r4_fill", 1'b0, 32'd4, 32'hF000_0000, 32'h0F00_0000);
      step("l4_fill", 1'b1, 32'd4, 32'h0000_000F, 32'h0000_00F0);

      // Hold: inputs change mid-cycle, Y stays put until the next edge
      step("hold_pre", 1'b1, 32'd3, 32'h0000_0011, 32'h0000_0088);
      D   = 32'hDEAD_BEEF;
      S   = 32'd5;
      LnR = 1'b0;
      #3;
      check("hold_mid", Y, 32'h0000_0088);
      @(posedge CLK);
      #1;
      check("hold_next", Y, 32'h06F5_6DF7);

      // Back-to-back random operations, one per cycle
      for (int i = 0; i < 300; i++) begin
         rd  = $urandom;
         sel = int'($urandom_range(0, 9));
         if (sel < 7)       rs = $urandom_range(0, 31);
         else if (sel == 7) rs = $urandom;
         else               rs = $urandom_range(32, 40);
         rl   = 1'($urandom_range(0, 1));
         expY = refShift(rd, rs, rl);
         step("rand", rl, rs, rd, expY);
         if ((i % 25) == 0) begin
            D   = ~rd;
            S   = rs + 32'd1;
            LnR = ~rl;
            #2;
            check("rand_hold", Y, expY);
         end
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // Safety net so the run always terminates
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
